divider: RTL and testbench
==========================

# divider

Sequential unsigned integer divider, the inverse of the team's repeated-addition multiplier. It latches an 8-bit dividend and a 4-bit divisor on a start request. It then computes quotient and remainder by restoring shift-subtract, one quotient bit per clock, and presents the result with a one-cycle `rdy` pulse. It sits beside the multiplier in the arithmetic block set and is driven by the same kind of control sequencer.

## Interface
Parameters:
- `DW`, 8: dividend and quotient width.
- `VW`, 4: divisor and remainder width.

Ports:
- `clk`, input, 1: clock, rising edge.
- `reset`, input, 1: reset, synchronous, active-low.
- `start`, input, 1: operation request, sampled only in IDLE.
- `A`, input, DW: dividend.
- `B`, input, VW: divisor.
- `Q`, output, DW: quotient; 0 whenever `rdy`=0.
- `R`, output, VW: remainder; 0 whenever `rdy`=0.
- `rdy`, output, 1: result valid, one-cycle pulse.
- `busy`, output, 1: high whenever state ≠ IDLE.
- `div_zero`, output, 1: divide-by-zero flag, valid with `rdy`.

## Operation
- States (2-bit encoding):
  - IDLE = 00.
  - CALC = 01.
  - DONE = 10.
  - Code 11 is illegal; it returns to IDLE on the next edge.
- IDLE with `start`=1 and `B`≠0:
  - latch `A` into the dividend shift register and `B` into the divisor register;
  - clear the partial remainder (VW+1 bits) and the iteration counter;
  - go to CALC.
- IDLE with `start`=1 and `B`=0:
  - go directly to DONE;
  - set `rdy`=1 and `div_zero`=1;
  - Q = all ones (DW'hFF at default), R = 0.
- CALC, one iteration per edge:
  - shift the dividend MSB into the partial remainder;
  - if partial ≥ divisor: subtract, quotient bit = 1; else quotient bit = 0;
  - shift the quotient bit in at the LSB.
  - After DW iterations: go to DONE and set `rdy`=1.
- DONE: hold for one cycle, then clear `rdy` and `div_zero` and go to IDLE.
- `start` is ignored in CALC and DONE. Operands latched at the start edge are immune to later changes on `A` and `B`.
- Arithmetic: all values unsigned.
  - The partial remainder is VW+1 bits wide, so the compare never overflows.
  - The final remainder is always < `B` and fits in VW bits.
  - Invariant: Q·B + R = A.
- Reset values: state IDLE, `rdy`=0, `div_zero`=0, `Q`=0, `R`=0, `busy`=0. Internal registers are cleared to 0.

## Timing
- `start` sampled at edge N (IDLE, `B`≠0):
  - `busy`=1 after edge N;
  - `rdy`=1 after edge N+DW (default 8) for exactly one cycle;
  - IDLE after edge N+DW+1;
  - the next `start` is accepted at edge N+DW+2.
- Throughput: one operation per DW+2 cycles.
- Divide-by-zero: `rdy` and `div_zero` are high after edge N; the block is back in IDLE after edge N+1.
- `start` held high continuously: a new operation starts every DW+2 cycles, with operands sampled at each accepting edge.
- Reset mid-operation: when `reset`=0 is sampled at any edge, all registers clear at that edge. No `rdy` pulse is produced for the aborted operation. A `start` sampled together with `reset`=0 is ignored.
- `Q`/`R` are gated by `rdy` combinationally and are valid only during the pulse. The consumer captures them on the edge ending the `rdy` cycle.

## Configuration
- `DIVIDER_DEBUG_EN` defined:
  - adds output `dbg_state` (2 bits), the current state;
  - adds output `dbg_count` ($clog2(DW)+1 bits), the iteration counter;
  - adds output `dbg_rem` (VW+1 bits), the partial remainder.
  - All three are driven directly from registers.
- `DIVIDER_DEBUG_EN` undefined: these ports and their assigns are absent. Functional behaviour is identical.

## Structure
- Package `divider_pkg`:
  - state encodings `ST_IDLE`, `ST_CALC`, `ST_DONE`;
  - default widths `DIV_DW`=8, `DIV_VW`=4.
- Sub-module `divider_step`: combinational single restoring step.
  - Inputs: partial remainder, incoming dividend bit, divisor.
  - Outputs: next partial remainder, quotient bit.
  - Instantiated once inside `divider`.

## Test plan
- Reset held low for 2 cycles with `start`=1, A=9, B=3 → `rdy`, `busy`, `Q`, `R` all 0; no operation starts.
- A=100, B=7, `start` pulsed at edge N → `busy` from N, `rdy` for one cycle after N+8, Q=14, R=2, `div_zero`=0.
- Boundary operands:
  - A=255, B=1 → Q=255, R=0;
  - A=5, B=15 → Q=0, R=5;
  - A=0, B=9 → Q=0, R=0.
- A=42, B=0 → `rdy`=1 and `div_zero`=1 one cycle after start, Q=255, R=0; IDLE the following cycle.
- A=200, B=9 started; A/B changed to 3/3 and `start` re-pulsed during CALC → Q=22, R=2, no second result. Separate run: reset asserted at iteration 4 → `busy`=0 next cycle, `rdy` never pulses.
- `start` held high, operand pairs (77,5) and (255,15) → results 15 r2 and 17 r0 exactly 10 cycles apart. For every result, the scoreboard checks Q·B + R = A.

Source files
------------

// File: rtl/divider_pkg.sv
// divider_pkg: state encodings and default widths for the sequential divider.
package divider_pkg;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;
  localparam int DIV_DW = 8;
  localparam int DIV_VW = 4;
endpackage

// File: rtl/divider_step.sv
// divider_step: one combinational restoring shift-subtract step.
module divider_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   rem,
  input  logic          din,
  input  logic [VW-1:0] dvs,
  output logic [VW:0]   nrem,
  output logic          qbit
);
  logic [VW:0] sh;
  always_comb begin
    sh   = {rem[VW-1:0], din};
    // a partial that already overflowed VW bits necessarily exceeds the divisor
    qbit = rem[VW] | (sh >= {1'b0, dvs});
    nrem = qbit ? sh - {1'b0, dvs} : sh;
  end
endmodule

// File: rtl/divider.sv
// divider: sequential unsigned restoring divider, one quotient bit per clock.
// Optional debug outputs dbg_state/dbg_count/dbg_rem when DIVIDER_DEBUG_EN is defined.
module divider
  import divider_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] A,
  input  logic [VW-1:0] B,
  output logic [DW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          rdy,
  output logic          busy,
  output logic          div_zero
`ifdef DIVIDER_DEBUG_EN
  ,
  output logic [1:0]              dbg_state,
  output logic [$clog2(DW):0]     dbg_count,
  output logic [VW:0]             dbg_rem
`endif
);
  localparam int CW = $clog2(DW) + 1;
  logic [1:0]    state;
  logic [DW-1:0] dvd;
  logic [VW-1:0] dvs;
  logic [VW:0]   rem;
  logic [VW:0]   nrem;
  logic [CW-1:0] cnt;
  logic          qbit;
  logic          dz;
  divider_step #(.VW(VW)) u_step (
    .rem  (rem),
    .din  (dvd[DW-1]),
    .dvs  (dvs),
    .nrem (nrem),
    .qbit (qbit)
  );
  // the dividend register doubles as the quotient register as bits shift through
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
      dz    <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      dvd   <= (B == '0) ? '1 : A;
      dvs   <= B;
      rem   <= '0;
      cnt   <= '0;
      dz    <= (B == '0);
      state <= (B == '0) ? ST_DONE : ST_CALC;
    end else if (state == ST_CALC) begin
      dvd <= {dvd[DW-2:0], qbit};
      rem <= nrem;
      cnt <= cnt + CW'(1);
      if (cnt == CW'(DW - 1)) state <= ST_DONE;
    end else if (state != ST_IDLE) begin
      dz    <= 1'b0;
      state <= ST_IDLE;
    end
  end
  always_comb begin
    rdy      = (state == ST_DONE);
    busy     = (state != ST_IDLE);
    div_zero = rdy & dz;
    Q        = rdy ? dvd : '0;
    R        = rdy ? rem[VW-1:0] : '0;
  end
`ifdef DIVIDER_DEBUG_EN
  assign dbg_state = state;
  assign dbg_count = cnt;
  assign dbg_rem   = rem;
`endif
endmodule

// File: tb/tb_divider.sv
// tb_divider: scoreboard bench for divider with directed vectors.
module tb_divider;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [3:0] B = '0;
  logic [7:0] Q;
  logic [3:0] R;
  logic       rdy, busy, div_zero;
`ifdef DIVIDER_DEBUG_EN
  logic [1:0] dbg_state;
  logic [3:0] dbg_count;
  logic [4:0] dbg_rem;
`endif

  divider dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .Q(Q), .R(R), .rdy(rdy), .busy(busy), .div_zero(div_zero)
`ifdef DIVIDER_DEBUG_EN
    , .dbg_state(dbg_state), .dbg_count(dbg_count), .dbg_rem(dbg_rem)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int a; int b; int q; int r; int dz; } exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_rdy = 0;
  int cyc = 0;
  int last_rdy = 0;
  int prev_rdy = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rdy) begin
      n_rdy++;
      prev_rdy = last_rdy;
      last_rdy = cyc;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rdy: got rdy=1 with Q=%0d R=%0d, expected no result", Q, R);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("Q(%0d/%0d)", e.a, e.b), int'(Q), e.q);
        chk($sformatf("R(%0d/%0d)", e.a, e.b), int'(R), e.r);
        chk($sformatf("div_zero(%0d/%0d)", e.a, e.b), int'(div_zero), e.dz);
        if (e.dz == 0) chk($sformatf("QB+R=A(%0d/%0d)", e.a, e.b), int'(Q) * e.b + int'(R), e.a);
      end
    end
  end

  task automatic push(input int a, input int b, input int q, input int r, input int dz);
    exp_t e;
    e.a = a; e.b = b; e.q = q; e.r = r; e.dz = dz;
    sb.push_back(e);
  endtask

  task automatic issue(input int a, input int b);
    @(negedge clk);
    A = 8'(a);
    B = 4'(b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 30 && busy; k++) @(negedge clk);
    if (busy) chk("wait_idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic run_op(input int a, input int b, input int q, input int r);
    push(a, b, q, r, 0);
    issue(a, b);
    wait_idle();
  endtask

  initial begin
    int base;
    // reset held with a pending request: nothing may start
    reset = 1'b0; start = 1'b1; A = 8'd9; B = 4'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rdy", int'(rdy), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_Q", int'(Q), 0);
    chk("reset_R", int'(R), 0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", int'(busy), 0);

    // 100/7 with cycle-exact timing
    push(100, 7, 14, 2, 0);
    issue(100, 7);
    chk("busy_after_N", int'(busy), 1);
    chk("rdy_after_N", int'(rdy), 0);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("rdy_early_N+%0d", i), int'(rdy), 0);
    end
    @(negedge clk);
    chk("rdy_at_N+8", int'(rdy), 1);
    @(negedge clk);
    chk("rdy_at_N+9", int'(rdy), 0);
    chk("busy_at_N+9", int'(busy), 0);
    @(negedge clk);

    run_op(255, 1, 255, 0);
    run_op(5, 15, 0, 5);
    run_op(0, 9, 0, 0);

    // divide by zero
    push(42, 0, 255, 0, 1);
    issue(42, 0);
    chk("dz_rdy", int'(rdy), 1);
    chk("dz_flag", int'(div_zero), 1);
    @(negedge clk);
    chk("dz_idle_busy", int'(busy), 0);
    chk("dz_rdy_clear", int'(rdy), 0);
    @(negedge clk);

    // operand/start changes during CALC are ignored
    base = n_rdy;
    push(200, 9, 22, 2, 0);
    issue(200, 9);
    A = 8'd3; B = 4'd3; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);
    chk("single_result", n_rdy - base, 1);

    // reset during iteration 4 aborts silently
    base = n_rdy;
    issue(123, 4);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_busy", int'(busy), 0);
    repeat (14) @(negedge clk);
    chk("abort_no_rdy", n_rdy - base, 0);

    // start held high: back-to-back operations
    base = n_rdy;
    push(77, 5, 15, 2, 0);
    push(255, 15, 17, 0, 0);
    @(negedge clk);
    A = 8'd77; B = 4'd5; start = 1'b1;
    @(negedge clk);
    A = 8'd255; B = 4'd15;
    repeat (12) @(negedge clk);
    start = 1'b0;
    wait_idle();
    @(negedge clk);
    chk("b2b_count", n_rdy - base, 2);
    chk("b2b_spacing", last_rdy - prev_rdy, 10);

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
